// File: rtl/seu_scrub_pkg.sv
// Shared types and helpers for the SEU scrub controller.
package seu_scrub_pkg;

  typedef enum logic [1:0] {StIdle, StWait, StScrub} scrub_state_e;

  // Helpers operate on a fixed 32-bit container; callers cast to their own width.
  localparam int unsigned SatW = 32;

  function automatic logic [SatW-1:0] sat_add(input logic [SatW-1:0] a,
                                              input logic [SatW-1:0] b,
                                              input logic [SatW-1:0] max_v);
    logic [SatW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_v}) ? max_v : sum[SatW-1:0];
  endfunction

  function automatic logic [SatW-1:0] popcount(input logic [SatW-1:0] v);
    logic [SatW-1:0] n;
    n = '0;
    for (int i = 0; i < SatW; i++) n = n + SatW'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/seu_sat_counter.sv
// Saturating up-counter with a variable increment and a clear that keeps the
// same-cycle increment.
module seu_sat_counter
  import seu_scrub_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) cnt_d = inc_i;
    else       cnt_d = W'(sat_add(SatW'(cnt_q), SatW'(inc_i), SatW'({W{1'b1}})));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seu_scrub_ctrl.sv
// Periodic scrub scheduler plus per-source and total SEU accounting with a
// registered readout port.
module seu_scrub_ctrl
  import seu_scrub_pkg::*;
#(
  parameter int unsigned NSRC = 4,
  parameter int unsigned CNTW = 8,
  parameter int unsigned TOTW = 16,
  parameter int unsigned PERW = 16,
  // One extra code point so the total counter is always addressable.
  parameter int unsigned IDXW = $clog2(NSRC + 1)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NSRC-1:0] err,
  input  logic            scrub_en,
  input  logic [PERW-1:0] scrub_period,
  output logic            scrub_req,
  input  logic            scrub_ack,
  input  logic            rd_req,
  input  logic [IDXW-1:0] rd_idx,
  input  logic            rd_clr,
  output logic            rd_valid,
  output logic [TOTW-1:0] rd_data,
  output logic            total_sat
);

  logic [CNTW-1:0] src_cnt [NSRC];
  logic [TOTW-1:0] total_cnt;
  logic [TOTW-1:0] total_inc;
  logic            rd_total;

  assign rd_total  = 32'(rd_idx) >= NSRC;
  assign total_inc = TOTW'(popcount(SatW'(err)));

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    seu_sat_counter #(.W(CNTW)) u_cnt (
      .clk_i  (clk),
      .rst_ni (rstn),
      .inc_i  (CNTW'(err[g])),
      .clr_i  (rd_req && rd_clr && (rd_idx == IDXW'(g))),
      .cnt_o  (src_cnt[g])
    );
  end

  seu_sat_counter #(.W(TOTW)) u_total (
    .clk_i  (clk),
    .rst_ni (rstn),
    .inc_i  (total_inc),
    .clr_i  (rd_req && rd_clr && rd_total),
    .cnt_o  (total_cnt)
  );

  scrub_state_e    state_d, state_q;
  logic [PERW-1:0] per_d, per_q;
  logic            scrub_req_d, scrub_req_q;
  logic            rd_valid_d, rd_valid_q;
  logic [TOTW-1:0] rd_data_d, rd_data_q;

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    case (state_q)
      StIdle: begin
        if (scrub_en) begin
          state_d = StWait;
          per_d   = scrub_period;
        end
      end
      StWait: begin
        if (!scrub_en)         state_d = StIdle;
        else if (per_q == '0)  state_d = StScrub;
        else                   per_d   = per_q - PERW'(1);
      end
      StScrub: begin
        // Disabling mid-request still waits for the ack before going idle.
        if (scrub_ack) begin
          if (scrub_en) begin
            state_d = StWait;
            per_d   = scrub_period;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    scrub_req_d = (state_d == StScrub);
  end

  // Readout captures the pre-update counter value.
  always_comb begin
    rd_valid_d = rd_req;
    rd_data_d  = rd_data_q;
    if (rd_req) begin
      if (rd_total) begin
        rd_data_d = total_cnt;
      end else begin
        for (int i = 0; i < NSRC; i++) begin
          if (rd_idx == IDXW'(i)) rd_data_d = TOTW'(src_cnt[i]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      per_q       <= '0;
      scrub_req_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      per_q       <= per_d;
      scrub_req_q <= scrub_req_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign scrub_req = scrub_req_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign total_sat = &total_cnt;

endmodule

// File: tb/tb_seu_scrub_ctrl.sv
// Directed bench for seu_scrub_ctrl: scrub scheduling, counting, readout, clear, reset.
module tb_seu_scrub_ctrl;

  localparam int unsigned NSRC = 4;
  localparam int unsigned CNTW = 8;
  localparam int unsigned TOTW = 16;
  localparam int unsigned PERW = 16;
  localparam int unsigned IDXW = 3;

  logic            clk = 1'b0;
  logic            rstn;
  logic [NSRC-1:0] err;
  logic            scrub_en;
  logic [PERW-1:0] scrub_period;
  logic            scrub_req;
  logic            scrub_ack;
  logic            rd_req;
  logic [IDXW-1:0] rd_idx;
  logic            rd_clr;
  logic            rd_valid;
  logic [TOTW-1:0] rd_data;
  logic            total_sat;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seu_scrub_ctrl #(.NSRC(NSRC), .CNTW(CNTW), .TOTW(TOTW), .PERW(PERW), .IDXW(IDXW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .err          (err),
    .scrub_en     (scrub_en),
    .scrub_period (scrub_period),
    .scrub_req    (scrub_req),
    .scrub_ack    (scrub_ack),
    .rd_req       (rd_req),
    .rd_idx       (rd_idx),
    .rd_clr       (rd_clr),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .total_sat    (total_sat)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int idx, input logic clr);
    rd_req = 1'b1;
    rd_idx = IDXW'(idx);
    rd_clr = clr;
    step();
    rd_req = 1'b0;
    rd_clr = 1'b0;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    err = '0; scrub_en = 1'b0; scrub_period = '0; scrub_ack = 1'b0;
    rd_req = 1'b0; rd_idx = '0; rd_clr = 1'b0;
    repeat (2) step();
    rstn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (scrub_req !== 1'b0) begin errors++; $display("FAIL reset_scrub_req got=%b exp=0", scrub_req); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (rd_data !== 16'd0) begin errors++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
    checks++; if (total_sat !== 1'b0) begin errors++; $display("FAIL reset_total_sat got=%b exp=0", total_sat); end
  endtask

  // Period 3, ack two cycles after each request rises: req in cycles 5..7, 12..14, 19..21.
  task automatic test_scrub_period3();
    logic exp;
    scrub_period = 16'd3;
    scrub_en = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      step();
      exp = (c >= 5) && (((c - 5) % 7) < 3);
      checks++; if (scrub_req !== exp) begin errors++; $display("FAIL p3_req cycle=%0d got=%b exp=%b", c, scrub_req, exp); end
      scrub_ack = exp && (((c - 5) % 7) == 2);
      if (c == 25) scrub_en = 1'b0;
    end
    for (int c = 26; c <= 29; c++) begin
      step();
      checks++; if (scrub_req !== 1'b0) begin errors++; $display("FAIL p3_idle_req cycle=%0d got=%b exp=0", c, scrub_req); end
    end
  endtask

  task automatic test_scrub_period0();
    logic exp;
    scrub_period = 16'd0;
    scrub_ack = 1'b1;
    scrub_en = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      exp = (c >= 2) && ((c % 2) == 0);
      checks++; if (scrub_req !== exp) begin errors++; $display("FAIL p0_req cycle=%0d got=%b exp=%b", c, scrub_req, exp); end
    end
    scrub_ack = 1'b0;
    scrub_en = 1'b0;
    step();
    checks++; if (scrub_req !== 1'b1) begin errors++; $display("FAIL p0_hold_req got=%b exp=1", scrub_req); end
    scrub_ack = 1'b1;
    for (int c = 10; c <= 13; c++) begin
      step();
      checks++; if (scrub_req !== 1'b0) begin errors++; $display("FAIL p0_idle_req cycle=%0d got=%b exp=0", c, scrub_req); end
    end
    scrub_ack = 1'b0;
  endtask

  task automatic test_saturation();
    err = 4'b0100;
    repeat (300) step();
    err = '0;
    do_read(2, 1'b0);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL sat_src_valid got=%b exp=1", rd_valid); end
    checks++; if (rd_data !== 16'd255) begin errors++; $display("FAIL sat_src_data got=%0d exp=255", rd_data); end
    do_read(4, 1'b0);
    checks++; if (rd_data !== 16'd300) begin errors++; $display("FAIL sat_total_data got=%0d exp=300", rd_data); end
    checks++; if (total_sat !== 1'b0) begin errors++; $display("FAIL sat_total_sat got=%b exp=0", total_sat); end
  endtask

  task automatic test_clear();
    apply_reset();
    err = 4'b1111;
    step();
    err = '0;
    do_read(4, 1'b0);
    checks++; if (rd_data !== 16'd4) begin errors++; $display("FAIL clr_total_before got=%0d exp=4", rd_data); end
    err = 4'b0010;
    do_read(1, 1'b1);
    err = '0;
    checks++; if (rd_data !== 16'd1) begin errors++; $display("FAIL clr_src_read got=%0d exp=1", rd_data); end
    do_read(1, 1'b0);
    checks++; if (rd_data !== 16'd1) begin errors++; $display("FAIL clr_src_after got=%0d exp=1", rd_data); end
  endtask

  task automatic test_back_to_back();
    logic [TOTW-1:0] exp [5];
    exp = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd5};
    for (int k = 0; k < 5; k++) begin
      rd_req = 1'b1;
      rd_idx = IDXW'(k);
      step();
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid idx=%0d got=%b exp=1", k, rd_valid); end
      checks++; if (rd_data !== exp[k]) begin errors++; $display("FAIL b2b_data idx=%0d got=%0d exp=%0d", k, rd_data, exp[k]); end
    end
    rd_req = 1'b0;
    step();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse got=%b exp=0", rd_valid); end
    err = 4'b0011;
    do_read(4, 1'b1);
    err = '0;
    checks++; if (rd_data !== 16'd5) begin errors++; $display("FAIL tclr_read got=%0d exp=5", rd_data); end
    do_read(4, 1'b0);
    checks++; if (rd_data !== 16'd2) begin errors++; $display("FAIL tclr_after got=%0d exp=2", rd_data); end
    do_read(0, 1'b0);
    checks++; if (rd_data !== 16'd2) begin errors++; $display("FAIL tclr_src0 got=%0d exp=2", rd_data); end
  endtask

  task automatic test_total_sat();
    apply_reset();
    err = 4'b1111;
    repeat (16383) step();
    err = '0;
    checks++; if (total_sat !== 1'b0) begin errors++; $display("FAIL tsat_below got=%b exp=0", total_sat); end
    err = 4'b1111;
    step();
    err = '0;
    checks++; if (total_sat !== 1'b1) begin errors++; $display("FAIL tsat_flag got=%b exp=1", total_sat); end
    do_read(4, 1'b0);
    checks++; if (rd_data !== 16'hFFFF) begin errors++; $display("FAIL tsat_total got=%0d exp=65535", rd_data); end
    do_read(0, 1'b0);
    checks++; if (rd_data !== 16'd255) begin errors++; $display("FAIL tsat_src0 got=%0d exp=255", rd_data); end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    scrub_period = 16'd0;
    scrub_ack = 1'b0;
    scrub_en = 1'b1;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      seen = scrub_req;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rmid_no_req got=0 exp=1 within 10 cycles"); end
    do_read(4, 1'b0);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL rmid_valid_pre got=%b exp=1", rd_valid); end
    rd_req = 1'b1;
    rd_idx = 3'd0;
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (scrub_req !== 1'b0) begin errors++; $display("FAIL rmid_req got=%b exp=0", scrub_req); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", rd_valid); end
    checks++; if (total_sat !== 1'b0) begin errors++; $display("FAIL rmid_total_sat got=%b exp=0", total_sat); end
    rd_req = 1'b0;
    scrub_en = 1'b0;
    step();
    rstn = 1'b1;
    step();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rmid_pending got=%b exp=0", rd_valid); end
    checks++; if (scrub_req !== 1'b0) begin errors++; $display("FAIL rmid_req_after got=%b exp=0", scrub_req); end
    do_read(4, 1'b0);
    checks++; if (rd_data !== 16'd0) begin errors++; $display("FAIL rmid_total got=%0d exp=0", rd_data); end
    do_read(2, 1'b0);
    checks++; if (rd_data !== 16'd0) begin errors++; $display("FAIL rmid_src2 got=%0d exp=0", rd_data); end
    // Starting from IDLE with period 0, the request appears two cycles after enable.
    scrub_en = 1'b1;
    step();
    checks++; if (scrub_req !== 1'b0) begin errors++; $display("FAIL rmid_idle_c1 got=%b exp=0", scrub_req); end
    step();
    checks++; if (scrub_req !== 1'b1) begin errors++; $display("FAIL rmid_idle_c2 got=%b exp=1", scrub_req); end
    scrub_en = 1'b0;
    scrub_ack = 1'b1;
    step();
    scrub_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scrub_period3();
    test_scrub_period0();
    test_saturation();
    test_clear();
    test_back_to_back();
    test_total_sat();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
